// File: rtl/epochtv1_pkg.sv
// Shared types and constants for the epochtv1 video path.
// Exports: color_t (4-bit colour index), rgb_t (8-bit r/g/b), rd_state_t (scan-out FSM states),
// SCV_ACTIVE_W (visible pixels per line) and PALETTE (fixed 16-entry SCV colour table).
package epochtv1_pkg;

  localparam int unsigned SCV_ACTIVE_W = 256;

  typedef logic [3:0] color_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    StIdle,
    StScan
  } rd_state_t;

  localparam rgb_t PALETTE [16] = '{
    24'h00009b, 24'h000000, 24'h0000ff, 24'ha100ff,
    24'h00ff00, 24'ha0ff9d, 24'h00ffff, 24'h00a100,
    24'hff0000, 24'hffa100, 24'hff00ff, 24'hffa09f,
    24'hffff00, 24'ha3a000, 24'ha1a09d, 24'hffffff
  };

endpackage

// File: rtl/epochtv1_linebuf_ram.sv
// One scanline bank: single-clock RAM with a write port and an asynchronous read port whose
// address can be overwritten with clr_data on the same edge (read-then-clear).
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port; clr/clr_data clear write.
// No reset: contents are undefined until written.
module epochtv1_linebuf_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          clr,
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] clr_data,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  assign rdata = mem[raddr];

  // The parent never writes and clears the same bank in one cycle; write wins if it ever did.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end else if (clr) begin
      mem[raddr] <= clr_data;
    end
  end

endmodule

// File: rtl/epochtv1_linebuf.sv
// Double-buffered scanline buffer with palette output stage.
// The render core writes colour indices into bank wr_bank while the other bank is scanned out,
// one pixel per CE, and cleared to BG behind the read pointer.
// Ports: CLK, RES (async, active high), CE (pixel enable), SWAP (line start), BG (clear colour),
// WR_EN/WR_X/WR_C (pixel write), DE/R/G/B (registered RGB, 2 CE latency), LINE_DONE.
module epochtv1_linebuf
  import epochtv1_pkg::*;
#(
  parameter int unsigned ACTIVE_W = SCV_ACTIVE_W,
  parameter int unsigned XW       = 8,
  parameter int unsigned CW       = 4
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          CE,
  input  logic          SWAP,
  input  logic [CW-1:0] BG,
  input  logic          WR_EN,
  input  logic [XW-1:0] WR_X,
  input  logic [CW-1:0] WR_C,
  output logic          DE,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B,
  output logic          LINE_DONE
);

  rd_state_t     state_q, state_d;
  logic          wr_bank;
  logic [XW-1:0] rd_x, rd_x_d;
  logic          rd_fire;
  logic          rd_last;

  logic          wr_ok;
  logic [CW-1:0] rdata0, rdata1, rd_c;

  logic          s1_valid, s1_last;
  logic [CW-1:0] s1_c;
  rgb_t          pix;

  assign rd_last = (rd_x == XW'(ACTIVE_W - 1));
  assign wr_ok   = CE & WR_EN & (32'(WR_X) < ACTIVE_W);
  assign rd_c    = wr_bank ? rdata0 : rdata1;

  // SWAP takes priority over an in-progress scan: no read or clear on that CE.
  always_comb begin
    state_d = state_q;
    rd_x_d  = rd_x;
    rd_fire = 1'b0;
    if (SWAP) begin
      state_d = StScan;
      rd_x_d  = '0;
    end else if (state_q == StScan) begin
      rd_fire = 1'b1;
      if (rd_last) begin
        state_d = StIdle;
        rd_x_d  = '0;
      end else begin
        rd_x_d = rd_x + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= StIdle;
      rd_x    <= '0;
      wr_bank <= 1'b0;
    end else if (CE) begin
      state_q <= state_d;
      rd_x    <= rd_x_d;
      if (SWAP) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  epochtv1_linebuf_ram #(
    .DEPTH(ACTIVE_W),
    .AW   (XW),
    .DW   (CW)
  ) u_bank0 (
    .clk     (CLK),
    .we      (wr_ok & ~wr_bank),
    .waddr   (WR_X),
    .wdata   (WR_C),
    .clr     (CE & rd_fire & wr_bank),
    .raddr   (rd_x),
    .clr_data(BG),
    .rdata   (rdata0)
  );

  epochtv1_linebuf_ram #(
    .DEPTH(ACTIVE_W),
    .AW   (XW),
    .DW   (CW)
  ) u_bank1 (
    .clk     (CLK),
    .we      (wr_ok & wr_bank),
    .waddr   (WR_X),
    .wdata   (WR_C),
    .clr     (CE & rd_fire & ~wr_bank),
    .raddr   (rd_x),
    .clr_data(BG),
    .rdata   (rdata1)
  );

  assign pix = PALETTE[color_t'(s1_c)];

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_c      <= '0;
      DE        <= 1'b0;
      R         <= '0;
      G         <= '0;
      B         <= '0;
      LINE_DONE <= 1'b0;
    end else if (CE) begin
      s1_valid  <= rd_fire;
      s1_last   <= rd_fire & rd_last;
      s1_c      <= rd_c;
      DE        <= s1_valid;
      R         <= s1_valid ? pix.r : 8'h00;
      G         <= s1_valid ? pix.g : 8'h00;
      B         <= s1_valid ? pix.b : 8'h00;
      LINE_DONE <= s1_valid & s1_last;
    end
  end

endmodule

// File: tb/tb_epochtv1_linebuf.sv
// Bench for epochtv1_linebuf: a reference model predicts each CE's output, pushes it to a
// scoreboard queue and compares it when the DUT produces that output one CE later.
// A second instance with ACTIVE_W=200 shares the inputs for the narrow-line checks.
module tb_epochtv1_linebuf;

  localparam int AW1 = 256;
  localparam int AW2 = 200;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       ce = 1'b0;
  logic       swap = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] bg = 4'h0;
  logic [3:0] wr_c = 4'h0;
  logic [7:0] wr_x = 8'h00;

  logic       de, done, de2, done2;
  logic [7:0] r, g, b, r2, g2, b2;

  always #5 clk = ~clk;

  epochtv1_linebuf #(.ACTIVE_W(AW1), .XW(8), .CW(4)) u_dut (
    .CLK(clk), .RES(res), .CE(ce), .SWAP(swap), .BG(bg), .WR_EN(wr_en), .WR_X(wr_x),
    .WR_C(wr_c), .DE(de), .R(r), .G(g), .B(b), .LINE_DONE(done)
  );

  epochtv1_linebuf #(.ACTIVE_W(AW2), .XW(8), .CW(4)) u_dut200 (
    .CLK(clk), .RES(res), .CE(ce), .SWAP(swap), .BG(bg), .WR_EN(wr_en), .WR_X(wr_x),
    .WR_C(wr_c), .DE(de2), .R(r2), .G(g2), .B(b2), .LINE_DONE(done2)
  );

  logic [23:0] pal [16] = '{
    24'h00009b, 24'h000000, 24'h0000ff, 24'ha100ff,
    24'h00ff00, 24'ha0ff9d, 24'h00ffff, 24'h00a100,
    24'hff0000, 24'hffa100, 24'hff00ff, 24'hffa09f,
    24'hffff00, 24'ha3a000, 24'ha1a09d, 24'hffffff
  };

  typedef struct packed {
    logic        chk_rgb;
    logic        de;
    logic        done;
    logic [23:0] rgb;
  } exp_t;

  exp_t       sb [$];
  logic [3:0] mem   [2][AW1];
  logic       known [2][AW1];
  int         m_wb, m_x;
  logic       m_act;
  int         total = 0;
  int         bad = 0;
  logic       mon2 = 1'b0;
  int         n2 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    m_wb  = 0;
    m_x   = 0;
    m_act = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < AW1; i++) known[k][i] = 1'b0;
    end
    sb.delete();
    z = '0;
    z.chk_rgb = 1'b1;
    sb.push_back(z);
  endtask

  // One pixel-enable step: CE high for one clock, then one idle clock.
  task automatic step(input logic sw, input logic we, input logic [7:0] x, input logic [3:0] c);
    exp_t e;
    int   rb;
    swap  = sw;
    wr_en = we;
    wr_x  = x;
    wr_c  = c;
    ce    = 1'b1;
    e = '0;
    e.chk_rgb = 1'b1;
    rb = 1 - m_wb;
    if (m_act && !sw) begin
      e.de      = 1'b1;
      e.done    = (m_x == AW1 - 1);
      e.chk_rgb = known[rb][m_x];
      e.rgb     = known[rb][m_x] ? pal[mem[rb][m_x]] : 24'h0;
      mem[rb][m_x]   = bg;
      known[rb][m_x] = 1'b1;
      if (m_x == AW1 - 1) begin
        m_act = 1'b0;
        m_x   = 0;
      end else begin
        m_x++;
      end
    end
    if (we && int'(x) < AW1) begin
      mem[m_wb][x]   = c;
      known[m_wb][x] = 1'b1;
    end
    if (sw) begin
      m_wb  = 1 - m_wb;
      m_x   = 0;
      m_act = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    ce    = 1'b0;
    swap  = 1'b0;
    wr_en = 1'b0;
    e = sb.pop_front();
    if (e.chk_rgb) begin
      check("px", 32'({de, done, r, g, b}), 32'({e.de, e.done, e.rgb}));
    end else begin
      check("px_de", 32'({de, done}), 32'({e.de, e.done}));
    end
    if (mon2 && de2) begin
      check("w200_px", 32'({r2, g2, b2}), 32'((n2 == 10) ? pal[7] : pal[3]));
      check("w200_done", 32'(done2), 32'(n2 == AW2 - 1));
      n2++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 4'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check("rst_out", 32'({de, done, r, g, b}), 32'h0);
    res = 1'b0;

    // Reset release: nothing comes out without a SWAP.
    idle(1000);

    // Line A, then last-write-wins collision at X=255.
    bg = 4'h3;
    for (int i = 0; i < AW1; i++) step(1'b0, 1'b1, 8'(i), 4'(i));
    step(1'b0, 1'b1, 8'd255, 4'd5);
    step(1'b0, 1'b1, 8'd255, 4'd9);
    step(1'b1, 1'b0, 8'h00, 4'h0);
    idle(260);
    // Other bank (never written), then line A's bank again: cleared to BG.
    step(1'b1, 1'b0, 8'h00, 4'h0);
    idle(260);
    step(1'b1, 1'b0, 8'h00, 4'h0);
    idle(260);

    // Line B, scan aborted at pixel 100, then revisit the aborted bank.
    for (int i = 0; i < AW1; i++) step(1'b0, 1'b1, 8'(i), 4'(i * 7));
    step(1'b1, 1'b0, 8'h00, 4'h0);
    idle(100);
    step(1'b1, 1'b0, 8'h00, 4'h0);
    idle(260);
    step(1'b1, 1'b0, 8'h00, 4'h0);
    idle(260);

    // Reset asserted between edges mid-scan.
    step(1'b1, 1'b0, 8'h00, 4'h0);
    idle(51);
    #3;
    res = 1'b1;
    #1;
    check("rst_mid", 32'({de, done, r, g, b}), 32'h0);
    check("rst_mid200", 32'({de2, done2, r2, g2, b2}), 32'h0);
    @(posedge clk);
    #1;
    res = 1'b0;
    model_reset();
    idle(20);

    // Narrow line: clear both banks, write X=210 (out of range for 200) and X=10.
    step(1'b1, 1'b0, 8'h00, 4'h0);
    idle(260);
    step(1'b1, 1'b0, 8'h00, 4'h0);
    idle(260);
    step(1'b0, 1'b1, 8'd210, 4'd5);
    step(1'b0, 1'b1, 8'd10, 4'd7);
    n2   = 0;
    mon2 = 1'b1;
    step(1'b1, 1'b0, 8'h00, 4'h0);
    idle(260);
    mon2 = 1'b0;
    check("w200_count", 32'(n2), 32'(AW2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
